data_mem_ctrl: RTL and testbench

// Parametrised successor to the 128x32 data memory: byte-addressed 32-bit data RAM with

---
 rtl/data_mem_pkg.sv | 26 ++
 rtl/mem_align.sv | 51 +++++
 rtl/data_mem_ctrl.sv | 100 ++++++++++
 tb/tb_data_mem_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and alignment rule for the data memory controller
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Reserved size is always treated as a faulting access.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - store lane replication / byte enables and load lane extraction / extension
module mem_align
  import data_mem_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] lane_data,
  output logic [3:0]  byte_en,
  output logic [31:0] load_data
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    lane_data = wdata;
    byte_en   = 4'b0000;
    case (size)
      SZ_BYTE: begin
        lane_data = {4{wdata[7:0]}};
        byte_en   = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        lane_data = {2{wdata[15:0]}};
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'd0:    sel_b = rword[7:0];
      2'd1:    sel_b = rword[15:8];
      2'd2:    sel_b = rword[23:16];
      default: sel_b = rword[31:24];
    endcase
    sel_h = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & sel_b[7]}}, sel_b};
      SZ_HALF: load_data = {{16{sign_ext & sel_h[15]}}, sel_h};
      SZ_WORD: load_data = rword;
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-addressed 32-bit data RAM with handshake, registered read and reset clear
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH          = 128,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int ADDR_W        = $clog2(DEPTH) + 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       WriteData,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       ReadData,
  output logic              misaligned
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  state_t           state;
  logic [IDX_W-1:0] clr_idx;
  logic [IDX_W-1:0] widx;
  mem_size_t        sz;
  logic             fault;
  logic             accept;
  logic             store_en;
  logic [31:0]      rword;
  logic [31:0]      wr_lane;
  logic [31:0]      load_val;
  logic [3:0]       be;

  assign sz       = mem_size_t'(size);
  assign widx     = address[ADDR_W-1:2];
  assign fault    = is_misaligned(sz, address[1:0]);
  assign accept   = req && ready && !RST;
  assign store_en = accept && we && !fault;
  assign rword    = mem[widx];

  mem_align u_align (
    .size      (sz),
    .addr_lo   (address[1:0]),
    .sign_ext  (sign_ext),
    .wdata     (WriteData),
    .rword     (rword),
    .lane_data (wr_lane),
    .byte_en   (be),
    .load_data (load_val)
  );

  // The array has no reset; it is zeroed by the clear sequencer instead.
  always_ff @(posedge CLK) begin
    if (state == ST_CLEAR && !RST) begin
      mem[clr_idx] <= 32'd0;
    end else if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wr_lane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_idx    <= '0;
      ready      <= 1'b0;
      rvalid     <= 1'b0;
      misaligned <= 1'b0;
      ReadData   <= 32'd0;
    end else begin
      rvalid     <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          ready <= 1'b1;
          if (accept) begin
            misaligned <= fault;
            if (!we) begin
              rvalid   <= 1'b1;
              ReadData <= fault ? 32'd0 : load_val;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl against a byte-array model
module tb_data_mem_ctrl;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = 9;
  localparam int NBYTES = DEPTH * 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [1:0]        size = 2'b00;
  logic              sign_ext = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [31:0]       WriteData = 32'd0;
  logic              ready;
  logic              rvalid;
  logic [31:0]       ReadData;
  logic              misaligned;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]  model_mem [NBYTES];
  logic [31:0] exp_rd;

  typedef struct {
    bit          w;
    logic [1:0]  sz;
    int          a;
    logic [31:0] d;
    bit          sx;
    bit          e_rv;
    bit          e_mis;
    logic [31:0] e_rd;
    string       name;
  } op_t;

  data_mem_ctrl #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req        (req),
    .we         (we),
    .size       (size),
    .sign_ext   (sign_ext),
    .address    (address),
    .WriteData  (WriteData),
    .ready      (ready),
    .rvalid     (rvalid),
    .ReadData   (ReadData),
    .misaligned (misaligned)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h00;
    exp_rd = 32'd0;
  endtask

  // Memory viewed as a flat little-endian byte array.
  function automatic void model_op(input bit w, input int sz, input int a, input logic [31:0] d,
                                   input bit sx, output bit e_rv, output bit e_mis,
                                   output logic [31:0] e_rd);
    int n;
    logic [31:0] v;
    e_mis = (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
    e_rv  = !w;
    n = 1 << sz;
    if (w && !e_mis) begin
      for (int k = 0; k < n; k++) model_mem[a + k] = d[8*k +: 8];
    end else if (!w) begin
      if (e_mis) begin
        exp_rd = 32'd0;
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(model_mem[a + k]) << (8 * k));
        if (sx && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        exp_rd = v;
      end
    end
    e_rd = exp_rd;
  endfunction

  task automatic drive(input bit w, input logic [1:0] sz, input int a, input logic [31:0] d,
                       input bit sx, output bit o_rv, output bit o_mis, output logic [31:0] o_rd);
    @(negedge CLK);
    req = 1'b1; we = w; size = sz; address = a[ADDR_W-1:0]; WriteData = d; sign_ext = sx;
    @(posedge CLK);
    #1;
    req = 1'b0;
    o_rv = rvalid; o_mis = misaligned; o_rd = ReadData;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    req = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic count_clear(output int lo);
    lo = 0;
    while (!ready && lo < 1000) begin
      lo++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    int lo;
    bit rv, mis;
    logic [31:0] rd, e_rd;
    bit e_rv, e_mis;
    pulse_reset();
    n_cmp++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || misaligned !== 1'b0 || ReadData !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b rvalid=%b mis=%b rd=%h, expected 0 0 0 00000000",
               ready, rvalid, misaligned, ReadData);
    end
    count_clear(lo);
    n_cmp++;
    if (lo !== 128) begin
      n_fail++;
      $display("FAIL reset_clear_len: ready low for %0d cycles, expected 128", lo);
    end
    for (int i = 0; i < 6; i++) begin
      int a;
      a = $urandom_range(0, DEPTH - 1) * 4;
      model_op(1'b0, 2, a, 32'd0, 1'b0, e_rv, e_mis, e_rd);
      drive(1'b0, 2'b10, a, 32'd0, 1'b0, rv, mis, rd);
      n_cmp++;
      if (rv !== 1'b1 || mis !== 1'b0 || rd !== 32'd0) begin
        n_fail++;
        $display("FAIL cleared_word @%h: rv=%b mis=%b rd=%h, expected 1 0 00000000", a, rv, mis, rd);
      end
    end
  endtask

  task automatic test_word();
    op_t tbl[3];
    bit rv, mis, e_rv, e_mis;
    logic [31:0] rd, e_rd;
    tbl[0] = '{1'b1, 2'b10, 'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'd0, "store_word"};
    tbl[1] = '{1'b0, 2'b10, 'h10, 32'd0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, "load_word"};
    tbl[2] = '{1'b0, 2'b01, 'h12, 32'd0, 1'b1, 1'b1, 1'b0, 32'hFFFFDEAD, "load_half_hi_s"};
    foreach (tbl[i]) begin
      model_op(tbl[i].w, int'(tbl[i].sz), tbl[i].a, tbl[i].d, tbl[i].sx, e_rv, e_mis, e_rd);
      drive(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, tbl[i].sx, rv, mis, rd);
      n_cmp++;
      if (rv !== tbl[i].e_rv || mis !== tbl[i].e_mis || (tbl[i].e_rv && rd !== tbl[i].e_rd)) begin
        n_fail++;
        $display("FAIL %s: rv=%b mis=%b rd=%h, expected %b %b %h", tbl[i].name, rv, mis, rd,
                 tbl[i].e_rv, tbl[i].e_mis, tbl[i].e_rd);
      end
    end
  endtask

  task automatic test_byte_sign();
    op_t tbl[5];
    bit rv, mis, e_rv, e_mis;
    logic [31:0] rd, e_rd;
    tbl[0] = '{1'b1, 2'b00, 'h21, 32'h12345680, 1'b0, 1'b0, 1'b0, 32'd0, "store_byte"};
    tbl[1] = '{1'b0, 2'b00, 'h21, 32'd0, 1'b1, 1'b1, 1'b0, 32'hFFFFFF80, "load_byte_s"};
    tbl[2] = '{1'b0, 2'b00, 'h21, 32'd0, 1'b0, 1'b1, 1'b0, 32'h00000080, "load_byte_u"};
    tbl[3] = '{1'b0, 2'b10, 'h20, 32'd0, 1'b1, 1'b1, 1'b0, 32'h00008000, "load_word_lane"};
    tbl[4] = '{1'b0, 2'b01, 'h20, 32'd0, 1'b1, 1'b1, 1'b0, 32'hFFFF8000, "load_half_s"};
    foreach (tbl[i]) begin
      model_op(tbl[i].w, int'(tbl[i].sz), tbl[i].a, tbl[i].d, tbl[i].sx, e_rv, e_mis, e_rd);
      drive(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, tbl[i].sx, rv, mis, rd);
      n_cmp++;
      if (rv !== tbl[i].e_rv || mis !== tbl[i].e_mis || (tbl[i].e_rv && rd !== tbl[i].e_rd)) begin
        n_fail++;
        $display("FAIL %s: rv=%b mis=%b rd=%h, expected %b %b %h", tbl[i].name, rv, mis, rd,
                 tbl[i].e_rv, tbl[i].e_mis, tbl[i].e_rd);
      end
    end
  endtask

  task automatic test_faults();
    op_t tbl[7];
    bit rv, mis, e_rv, e_mis;
    logic [31:0] rd, e_rd;
    tbl[0] = '{1'b1, 2'b10, 'h10, 32'h11223344, 1'b0, 1'b0, 1'b0, 32'd0, "pre_store"};
    tbl[1] = '{1'b0, 2'b10, 'h10, 32'd0, 1'b0, 1'b1, 1'b0, 32'h11223344, "pre_load"};
    tbl[2] = '{1'b1, 2'b01, 'h13, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'h11223344, "store_half_mis"};
    tbl[3] = '{1'b0, 2'b10, 'h02, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0, "load_word_mis"};
    tbl[4] = '{1'b0, 2'b11, 'h10, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0, "load_rsvd"};
    tbl[5] = '{1'b1, 2'b11, 'h10, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 32'd0, "store_rsvd"};
    tbl[6] = '{1'b0, 2'b10, 'h10, 32'd0, 1'b0, 1'b1, 1'b0, 32'h11223344, "no_write_check"};
    foreach (tbl[i]) begin
      model_op(tbl[i].w, int'(tbl[i].sz), tbl[i].a, tbl[i].d, tbl[i].sx, e_rv, e_mis, e_rd);
      drive(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].d, tbl[i].sx, rv, mis, rd);
      n_cmp++;
      // A faulting store must also leave ReadData holding the previous load result.
      if (rv !== tbl[i].e_rv || mis !== tbl[i].e_mis ||
          ((tbl[i].e_rv || i == 2) && rd !== tbl[i].e_rd)) begin
        n_fail++;
        $display("FAIL %s: rv=%b mis=%b rd=%h, expected %b %b %h", tbl[i].name, rv, mis, rd,
                 tbl[i].e_rv, tbl[i].e_mis, tbl[i].e_rd);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int lo;
    bit rv, mis, e_rv, e_mis;
    logic [31:0] rd, e_rd;
    model_op(1'b1, 2, 'h40, 32'hCAFEF00D, 1'b0, e_rv, e_mis, e_rd);
    drive(1'b1, 2'b10, 'h40, 32'hCAFEF00D, 1'b0, rv, mis, rd);
    pulse_reset();
    repeat (50) @(negedge CLK);
    n_cmp++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear_ready: ready=%b after 50 clear cycles, expected 0", ready);
    end
    pulse_reset();
    count_clear(lo);
    n_cmp++;
    if (lo !== 128) begin
      n_fail++;
      $display("FAIL restart_clear_len: ready low for %0d cycles after RST, expected 128", lo);
    end
    model_op(1'b0, 2, 'h40, 32'd0, 1'b0, e_rv, e_mis, e_rd);
    drive(1'b0, 2'b10, 'h40, 32'd0, 1'b0, rv, mis, rd);
    n_cmp++;
    if (rv !== 1'b1 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL restart_cleared: rv=%b rd=%h, expected 1 00000000", rv, rd);
    end
  endtask

  task automatic test_req_during_clear();
    int lo;
    bit seen;
    bit rv, mis, e_rv, e_mis;
    logic [31:0] rd, e_rd;
    pulse_reset();
    lo = 0;
    seen = 1'b0;
    while (!ready && lo < 1000) begin
      req = 1'b1; we = lo[0]; size = 2'b10; address = 9'h040; WriteData = 32'h12345678;
      sign_ext = 1'b0;
      @(negedge CLK);
      seen = seen | rvalid | misaligned;
      lo++;
    end
    req = 1'b0;
    n_cmp++;
    if (lo !== 128 || seen !== 1'b0) begin
      n_fail++;
      $display("FAIL req_during_clear: cycles=%0d pulses_seen=%b, expected 128 0", lo, seen);
    end
    model_op(1'b0, 2, 'h40, 32'd0, 1'b0, e_rv, e_mis, e_rd);
    drive(1'b0, 2'b10, 'h40, 32'd0, 1'b0, rv, mis, rd);
    n_cmp++;
    if (rv !== 1'b1 || rd !== 32'd0) begin
      n_fail++;
      $display("FAIL dropped_store: rv=%b rd=%h, expected 1 00000000", rv, rd);
    end
  endtask

  task automatic test_back_to_back(input int n_ops, input bit gaps, input string tag);
    bit rv, mis, e_rv, e_mis, w, sx;
    logic [31:0] rd, e_rd, d;
    int sz, a;
    for (int i = 0; i < n_ops; i++) begin
      if (gaps && $urandom_range(0, 4) == 0) begin
        @(negedge CLK);
        req = 1'b0;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (rvalid !== 1'b0 || misaligned !== 1'b0 || ReadData !== exp_rd) begin
          n_fail++;
          $display("FAIL %s idle[%0d]: rv=%b mis=%b rd=%h, expected 0 0 %h", tag, i,
                   rvalid, misaligned, ReadData, exp_rd);
        end
      end
      w  = $urandom_range(0, 1);
      sx = $urandom_range(0, 1);
      sz = $urandom_range(0, 3);
      d  = $urandom;
      a  = gaps && $urandom_range(0, 3) == 0 ? $urandom_range(0, NBYTES - 1)
                                             : 'h50 + $urandom_range(0, 15);
      if (sz < 3 && $urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
      model_op(w, sz, a, d, sx, e_rv, e_mis, e_rd);
      drive(w, sz[1:0], a, d, sx, rv, mis, rd);
      n_cmp++;
      if (rv !== e_rv || mis !== e_mis || rd !== e_rd) begin
        n_fail++;
        $display("FAIL %s[%0d] we=%0d sz=%0d a=%h sx=%0d: rv=%b mis=%b rd=%h, expected %b %b %h",
                 tag, i, w, sz, a, sx, rv, mis, rd, e_rv, e_mis, e_rd);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_word();
    test_byte_sign();
    test_faults();
    test_back_to_back(60, 1'b0, "back_to_back");
    test_back_to_back(400, 1'b1, "random");
    test_reset_mid_clear();
    test_req_during_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
